// File: rtl/calc_centroid.sv
// -----------------------------------------------------------------------------
// calc_centroid
//
// Computes the pixel count and centroid of the set pixels of a binarized image
// inside a rectangular region of interest. The image is read one row at a time
// from an external memory. For every row in the ROI the masked pixels are
// counted and their column indices summed. The running sums S, SX and SY are
// then divided by two parallel restoring dividers, giving the centroid in
// unsigned fixed point with FRAC_BITS fractional bits.
//
// Ports
//   CCLK        : clock, rising edge
//   RST         : synchronous active-high reset
//   iSTART      : frame start pulse, accepted only while idle
//   iX0/iX1     : inclusive ROI column bounds
//   iY0/iY1     : inclusive ROI row bounds
//   iMIN_AREA   : minimum pixel count for a valid object
//   oRD_EN      : one-cycle row read request
//   oADDR       : requested row address, valid with oRD_EN
//   iDATA_EN    : row data valid
//   iMEMIN      : row bitmap, bit i = pixel in column i
//   oBUSY       : high whenever a frame is in progress
//   oVALID      : result valid, held until iREADY
//   iREADY      : result accept
//   oNO_OBJ     : no object found (empty, too small, or invalid ROI)
//   oERR        : invalid ROI
//   oSUM_S      : pixel count
//   oCX/oCY     : centroid, FRAC_BITS fractional bits
// -----------------------------------------------------------------------------
module calc_centroid #(
    parameter int ADDR_WIDTH  = 11,
    parameter int MDATA_WIDTH = 640,
    parameter int FRAC_BITS   = 4,
    localparam int XW  = $clog2(MDATA_WIDTH),
    localparam int QW  = ((XW > ADDR_WIDTH) ? XW : ADDR_WIDTH) + FRAC_BITS,
    localparam int S_W = ADDR_WIDTH + XW + 1
) (
    input  logic                   CCLK,
    input  logic                   RST,
    input  logic                   iSTART,
    input  logic [XW-1:0]          iX0,
    input  logic [XW-1:0]          iX1,
    input  logic [ADDR_WIDTH-1:0]  iY0,
    input  logic [ADDR_WIDTH-1:0]  iY1,
    input  logic [S_W-1:0]         iMIN_AREA,
    output logic                   oRD_EN,
    output logic [ADDR_WIDTH-1:0]  oADDR,
    input  logic                   iDATA_EN,
    input  logic [MDATA_WIDTH-1:0] iMEMIN,
    output logic                   oBUSY,
    output logic                   oVALID,
    input  logic                   iREADY,
    output logic                   oNO_OBJ,
    output logic                   oERR,
    output logic [S_W-1:0]         oSUM_S,
    output logic [QW-1:0]          oCX,
    output logic [QW-1:0]          oCY
);

    // Derived widths
    localparam int CW  = XW + 1;              // per-row pixel count
    localparam int SRW = 2 * XW;              // per-row column-index sum
    localparam int PW  = ADDR_WIDTH + CW;     // per-row row*count product
    localparam int SXW = S_W + XW;            // SX accumulator
    localparam int SYW = S_W + ADDR_WIDTH;    // SY accumulator
    localparam int DW  = S_W + QW;            // dividend (sum << FRAC_BITS)
    localparam int DCW = $clog2(QW);          // divider step counter

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DIV,
        ST_OUT
    } state_t;

    state_t                  state_reg;

    // Frame parameters captured at start
    logic [XW-1:0]           x0_reg;
    logic [XW-1:0]           x1_reg;
    logic [ADDR_WIDTH-1:0]   y1_reg;
    logic [S_W-1:0]          min_area_reg;
    logic [ADDR_WIDTH-1:0]   row_reg;

    // Accumulators
    logic [S_W-1:0]          s_reg;
    logic [SXW-1:0]          sx_reg;
    logic [SYW-1:0]          sy_reg;

    // Dividers: index 0 = X, index 1 = Y
    logic [1:0][S_W-1:0]     rem_reg;
    logic [1:0][QW-1:0]      lo_reg;
    logic [1:0][QW-2:0]      q_reg;
    logic [DCW-1:0]          div_cnt_reg;

    // Registered outputs
    logic                    rd_en_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic                    valid_reg;
    logic                    no_obj_reg;
    logic                    err_reg;
    logic [S_W-1:0]          sum_reg;
    logic [QW-1:0]           cx_reg;
    logic [QW-1:0]           cy_reg;

    // -------------------------------------------------------------------------
    // Row statistics over the ROI columns
    // -------------------------------------------------------------------------
    logic [MDATA_WIDTH-1:0]  col_mask;
    logic [MDATA_WIDTH-1:0]  masked_row;
    logic [CW-1:0]           row_cnt;
    logic [SRW-1:0]          row_sx;
    logic [PW-1:0]           row_sy;

    generate
        for (genvar gi = 0; gi < MDATA_WIDTH; gi++) begin : g_mask
            assign col_mask[gi] = (XW'(gi) >= x0_reg) && (XW'(gi) <= x1_reg);
        end
    endgenerate

    assign masked_row = iMEMIN & col_mask;

    always_comb begin
        row_cnt = '0;
        row_sx  = '0;
        for (int i = 0; i < MDATA_WIDTH; i++) begin
            if (masked_row[i]) begin
                row_cnt = row_cnt + CW'(1);
                row_sx  = row_sx + SRW'(i);
            end
        end
    end

    assign row_sy = PW'(row_reg) * PW'(row_cnt);

    // Sums including the row currently being delivered
    logic [S_W-1:0]          s_next;
    logic [SXW-1:0]          sx_next;
    logic [SYW-1:0]          sy_next;

    assign s_next  = s_reg  + S_W'(row_cnt);
    assign sx_next = sx_reg + SXW'(row_sx);
    assign sy_next = sy_reg + SYW'(row_sy);

    // -------------------------------------------------------------------------
    // Restoring dividers
    //
    // Dividend = sum << FRAC_BITS. Because every column index is at most
    // 2^XW-1 and every row index at most 2^ADDR_WIDTH-1, the quotient always
    // fits in QW bits, so the dividend bits above the low QW bits are smaller
    // than S and can seed the partial remainder directly. Only QW steps are
    // then needed, each producing one quotient bit MSB first.
    // -------------------------------------------------------------------------
    logic [1:0][DW-1:0]      num_w;
    logic [1:0][S_W:0]       trial;
    logic [1:0]              take;
    logic [1:0][S_W-1:0]     rem_nxt;
    logic [1:0][QW-1:0]      q_nxt;

    assign num_w[0] = DW'(sx_next) << FRAC_BITS;
    assign num_w[1] = DW'(sy_next) << FRAC_BITS;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_div
            assign trial[gi]   = {rem_reg[gi], lo_reg[gi][QW-1]};
            assign take[gi]    = (trial[gi] >= {1'b0, s_reg});
            assign rem_nxt[gi] = take[gi] ? S_W'(trial[gi] - {1'b0, s_reg})
                                          : trial[gi][S_W-1:0];
            assign q_nxt[gi]   = {q_reg[gi], take[gi]};
        end
    endgenerate

    // ROI sanity check on the raw inputs at start
    logic roi_bad;
    assign roi_bad = (iX0 > iX1) || (iY0 > iY1) ||
                     ({1'b0, iX1} > CW'(MDATA_WIDTH - 1));

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge CCLK) begin
        if (RST) begin
            state_reg    <= ST_IDLE;
            x0_reg       <= '0;
            x1_reg       <= '0;
            y1_reg       <= '0;
            min_area_reg <= '0;
            row_reg      <= '0;
            s_reg        <= '0;
            sx_reg       <= '0;
            sy_reg       <= '0;
            rem_reg      <= '0;
            lo_reg       <= '0;
            q_reg        <= '0;
            div_cnt_reg  <= '0;
            rd_en_reg    <= 1'b0;
            addr_reg     <= '0;
            valid_reg    <= 1'b0;
            no_obj_reg   <= 1'b0;
            err_reg      <= 1'b0;
            sum_reg      <= '0;
            cx_reg       <= '0;
            cy_reg       <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (iSTART) begin
                        x0_reg       <= iX0;
                        x1_reg       <= iX1;
                        y1_reg       <= iY1;
                        min_area_reg <= iMIN_AREA;
                        row_reg      <= iY0;
                        s_reg        <= '0;
                        sx_reg       <= '0;
                        sy_reg       <= '0;
                        if (roi_bad) begin
                            // Report immediately without touching memory
                            state_reg  <= ST_OUT;
                            valid_reg  <= 1'b1;
                            err_reg    <= 1'b1;
                            no_obj_reg <= 1'b1;
                            sum_reg    <= '0;
                            cx_reg     <= '0;
                            cy_reg     <= '0;
                        end else begin
                            state_reg <= ST_REQ;
                            rd_en_reg <= 1'b1;
                            addr_reg  <= iY0;
                        end
                    end
                end

                ST_REQ: begin
                    rd_en_reg <= 1'b0;
                    state_reg <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (iDATA_EN) begin
                        s_reg  <= s_next;
                        sx_reg <= sx_next;
                        sy_reg <= sy_next;
                        if (row_reg != y1_reg) begin
                            row_reg   <= row_reg + ADDR_WIDTH'(1);
                            addr_reg  <= row_reg + ADDR_WIDTH'(1);
                            rd_en_reg <= 1'b1;
                            state_reg <= ST_REQ;
                        end else if ((s_next >= min_area_reg) && (s_next != '0)) begin
                            // Seed the dividers straight from the final sums
                            for (int g = 0; g < 2; g++) begin
                                rem_reg[g] <= num_w[g][DW-1:QW];
                                lo_reg[g]  <= num_w[g][QW-1:0];
                            end
                            q_reg       <= '0;
                            div_cnt_reg <= '0;
                            state_reg   <= ST_DIV;
                        end else begin
                            state_reg  <= ST_OUT;
                            valid_reg  <= 1'b1;
                            no_obj_reg <= 1'b1;
                            err_reg    <= 1'b0;
                            sum_reg    <= s_next;
                            cx_reg     <= '0;
                            cy_reg     <= '0;
                        end
                    end
                end

                ST_DIV: begin
                    for (int g = 0; g < 2; g++) begin
                        rem_reg[g] <= rem_nxt[g];
                        lo_reg[g]  <= lo_reg[g] << 1;
                        q_reg[g]   <= q_nxt[g][QW-2:0];
                    end
                    div_cnt_reg <= div_cnt_reg + DCW'(1);
                    if (div_cnt_reg == DCW'(QW - 1)) begin
                        state_reg  <= ST_OUT;
                        valid_reg  <= 1'b1;
                        no_obj_reg <= 1'b0;
                        err_reg    <= 1'b0;
                        sum_reg    <= s_reg;
                        cx_reg     <= q_nxt[0];
                        cy_reg     <= q_nxt[1];
                    end
                end

                ST_OUT: begin
                    // Result registers are left untouched so they stay readable
                    if (iREADY) begin
                        valid_reg <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign oRD_EN  = rd_en_reg;
    assign oADDR   = addr_reg;
    assign oBUSY   = (state_reg != ST_IDLE);
    assign oVALID  = valid_reg;
    assign oNO_OBJ = no_obj_reg;
    assign oERR    = err_reg;
    assign oSUM_S  = sum_reg;
    assign oCX     = cx_reg;
    assign oCY     = cy_reg;

endmodule

// File: tb/tb_calc_centroid.sv
// -----------------------------------------------------------------------------
// tb_calc_centroid
//
// Scoreboard bench for calc_centroid (16-pixel rows, 4-bit rows, 2 fraction
// bits). The driver pushes hand-computed expected results when it starts a
// frame; a monitor pops and compares whenever oVALID rises. A memory model
// answers each read one cycle later.
// -----------------------------------------------------------------------------
module tb_calc_centroid;

    localparam int AW = 4;
    localparam int MW = 16;
    localparam int FB = 2;
    localparam int XW = 4;
    localparam int QW = 6;
    localparam int SW = 9;

    logic          CCLK = 1'b0;
    logic          RST = 1'b1;
    logic          iSTART = 1'b0;
    logic [XW-1:0] iX0 = '0;
    logic [XW-1:0] iX1 = '0;
    logic [AW-1:0] iY0 = '0;
    logic [AW-1:0] iY1 = '0;
    logic [SW-1:0] iMIN_AREA = '0;
    logic          oRD_EN;
    logic [AW-1:0] oADDR;
    logic          iDATA_EN = 1'b0;
    logic [MW-1:0] iMEMIN = '0;
    logic          oBUSY;
    logic          oVALID;
    logic          iREADY = 1'b1;
    logic          oNO_OBJ;
    logic          oERR;
    logic [SW-1:0] oSUM_S;
    logic [QW-1:0] oCX;
    logic [QW-1:0] oCY;

    calc_centroid #(
        .ADDR_WIDTH  (AW),
        .MDATA_WIDTH (MW),
        .FRAC_BITS   (FB)
    ) dut (
        .CCLK      (CCLK),
        .RST       (RST),
        .iSTART    (iSTART),
        .iX0       (iX0),
        .iX1       (iX1),
        .iY0       (iY0),
        .iY1       (iY1),
        .iMIN_AREA (iMIN_AREA),
        .oRD_EN    (oRD_EN),
        .oADDR     (oADDR),
        .iDATA_EN  (iDATA_EN),
        .iMEMIN    (iMEMIN),
        .oBUSY     (oBUSY),
        .oVALID    (oVALID),
        .iREADY    (iREADY),
        .oNO_OBJ   (oNO_OBJ),
        .oERR      (oERR),
        .oSUM_S    (oSUM_S),
        .oCX       (oCX),
        .oCY       (oCY)
    );

    always #5 CCLK = ~CCLK;

    typedef struct {
        string name;
        int    sum;
        int    cx;
        int    cy;
        int    no_obj;
        int    err;
        int    lat;
        int    start;
    } exp_t;

    exp_t          sb[$];
    int            n_assert = 0;
    int            n_fail = 0;
    int            n_done = 0;
    int            rd_cnt = 0;
    int            cyc = 0;
    bit            mem_en = 1'b1;
    logic [MW-1:0] mem [16];

    always @(posedge CCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_assert++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Memory model: one-cycle response to each read request
    initial begin
        logic [AW-1:0] a;
        forever begin
            @(negedge CCLK);
            if (oRD_EN && mem_en) begin
                a = oADDR;
                @(posedge CCLK);
                #1;
                iMEMIN   = mem[a];
                iDATA_EN = 1'b1;
                @(posedge CCLK);
                #1;
                iDATA_EN = 1'b0;
            end
        end
    end

    // Monitor: compare on each new result
    initial begin
        bit   prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge CCLK);
            if (oRD_EN) rd_cnt++;
            if (RST) begin
                prev_valid = 1'b0;
            end else begin
                if (oVALID && !prev_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, ".sum"},    int'(oSUM_S),  e.sum);
                        chk({e.name, ".cx"},     int'(oCX),     e.cx);
                        chk({e.name, ".cy"},     int'(oCY),     e.cy);
                        chk({e.name, ".no_obj"}, int'(oNO_OBJ), e.no_obj);
                        chk({e.name, ".err"},    int'(oERR),    e.err);
                        chk({e.name, ".lat"},    cyc - e.start, e.lat);
                        $display("result %s: sum=%0d cx=%0d cy=%0d no_obj=%0d err=%0d lat=%0d",
                                 e.name, oSUM_S, oCX, oCY, oNO_OBJ, oERR, cyc - e.start);
                    end
                    n_done++;
                end
                prev_valid = oVALID;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = '0;
    endtask

    task automatic start_frame(input string name, input int x0, input int x1,
                               input int y0, input int y1, input int mina,
                               input int esum, input int ecx, input int ecy,
                               input int eno, input int eerr, input int elat,
                               input bit push);
        exp_t e;
        @(posedge CCLK);
        #1;
        iX0       = XW'(x0);
        iX1       = XW'(x1);
        iY0       = AW'(y0);
        iY1       = AW'(y1);
        iMIN_AREA = SW'(mina);
        iSTART    = 1'b1;
        if (push) begin
            e.name   = name;
            e.sum    = esum;
            e.cx     = ecx;
            e.cy     = ecy;
            e.no_obj = eno;
            e.err    = eerr;
            e.lat    = elat;
            e.start  = cyc;
            sb.push_back(e);
        end
        @(posedge CCLK);
        #1;
        iSTART = 1'b0;
        // Scramble the frame inputs; the block must use its latched copies
        iX0       = XW'(7);
        iX1       = XW'(6);
        iY0       = AW'(5);
        iY1       = AW'(4);
        iMIN_AREA = '1;
    endtask

    task automatic wait_result(input string name, input int base);
        int t;
        t = 0;
        while (n_done == base && t < 300) begin
            @(posedge CCLK);
            t++;
        end
        if (n_done == base) chk({name, ".timeout"}, 0, 1);
    endtask

    task automatic run_frame(input string name, input int x0, input int x1,
                             input int y0, input int y1, input int mina,
                             input int esum, input int ecx, input int ecy,
                             input int eno, input int eerr, input int elat);
        int base;
        base = n_done;
        start_frame(name, x0, x1, y0, y1, mina, esum, ecx, ecy, eno, eerr, elat, 1'b1);
        wait_result(name, base);
        @(posedge CCLK);
        @(posedge CCLK);
        #1;
        chk({name, ".idle"}, int'(oBUSY), 0);
    endtask

    initial begin
        int r0;
        int base;
        int t;

        clear_mem();
        repeat (3) @(posedge CCLK);
        #1;
        RST = 1'b0;
        chk("reset.valid",  int'(oVALID),  0);
        chk("reset.busy",   int'(oBUSY),   0);
        chk("reset.rd_en",  int'(oRD_EN),  0);
        chk("reset.addr",   int'(oADDR),   0);
        chk("reset.sum",    int'(oSUM_S),  0);
        chk("reset.cx",     int'(oCX),     0);
        chk("reset.cy",     int'(oCY),     0);
        chk("reset.no_obj", int'(oNO_OBJ), 0);
        chk("reset.err",    int'(oERR),    0);

        // Single pixel at (5,3)
        clear_mem();
        mem[3] = 16'h0020;
        run_frame("single", 0, 15, 0, 15, 1, 1, 20, 12, 0, 0, 39);

        // 2x2 block at x4-5, y6-7
        clear_mem();
        mem[6] = 16'h0030;
        mem[7] = 16'h0030;
        run_frame("block", 0, 15, 0, 15, 1, 4, 18, 26, 0, 0, 39);

        // Same block below the minimum area
        run_frame("min_area", 0, 15, 0, 15, 5, 4, 0, 0, 1, 0, 33);

        // Empty frame
        clear_mem();
        run_frame("empty", 0, 15, 0, 15, 1, 0, 0, 0, 1, 0, 33);

        // Column ROI excludes the pixel at x1
        clear_mem();
        mem[2] = 16'h0402;
        run_frame("roi_x", 8, 15, 0, 15, 1, 1, 40, 8, 0, 0, 39);

        // Invalid ROIs: no reads at all
        r0 = rd_cnt;
        run_frame("bad_x", 9, 3, 0, 15, 1, 0, 0, 0, 1, 1, 1);
        chk("bad_x.no_rd", rd_cnt - r0, 0);
        r0 = rd_cnt;
        run_frame("bad_y", 0, 15, 7, 2, 1, 0, 0, 0, 1, 1, 1);
        chk("bad_y.no_rd", rd_cnt - r0, 0);

        // Three-row ROI, rows outside are full and must not be counted;
        // S=5 SX=25 SY=8 -> cx=100/5=20, cy=32/5=6 (truncated)
        clear_mem();
        mem[0] = 16'hFFFF;
        mem[1] = 16'h0007;
        mem[2] = 16'h0080;
        mem[3] = 16'h8000;
        mem[4] = 16'hFFFF;
        r0 = rd_cnt;
        run_frame("rows", 0, 15, 1, 3, 1, 5, 20, 6, 0, 0, 13);
        chk("rows.rd_count", rd_cnt - r0, 3);

        // Single-pixel ROI at the far corner
        clear_mem();
        mem[15] = 16'h8000;
        mem[14] = 16'h8000;
        run_frame("corner", 15, 15, 15, 15, 1, 1, 60, 60, 0, 0, 9);

        // Back-pressure: hold OUT for 10 cycles while iSTART pulses
        clear_mem();
        mem[3] = 16'h0020;
        iREADY = 1'b0;
        base = n_done;
        start_frame("hold", 0, 15, 0, 15, 1, 1, 20, 12, 0, 0, 39, 1'b1);
        wait_result("hold", base);
        for (int i = 0; i < 10; i++) begin
            @(posedge CCLK);
            #1;
            chk("hold.valid", int'(oVALID), 1);
            chk("hold.cx",    int'(oCX),    20);
            chk("hold.cy",    int'(oCY),    12);
            chk("hold.sum",   int'(oSUM_S), 1);
            iX0    = XW'(0);
            iX1    = XW'(15);
            iSTART = (i % 2 == 0);
        end
        // iSTART coincides with the handshake cycle
        @(posedge CCLK);
        #1;
        iREADY = 1'b1;
        iSTART = 1'b1;
        @(posedge CCLK);
        #1;
        iSTART = 1'b0;
        chk("hold.valid_drop", int'(oVALID), 0);
        chk("hold.start_ignored", int'(oBUSY), 0);
        chk("hold.cx_kept", int'(oCX), 20);
        @(posedge CCLK);
        #1;
        chk("hold.still_idle", int'(oBUSY), 0);

        // Reset while waiting for row data
        mem_en = 1'b0;
        start_frame("rst", 0, 15, 9, 15, 1, 0, 0, 0, 0, 0, 0, 1'b0);
        t = 0;
        while (!oRD_EN && t < 20) begin
            @(posedge CCLK);
            #1;
            t++;
        end
        chk("rst.rd_en", int'(oRD_EN), 1);
        chk("rst.addr",  int'(oADDR),  9);
        @(posedge CCLK);
        #1;
        chk("rst.busy_in_wait", int'(oBUSY), 1);
        RST = 1'b1;
        @(posedge CCLK);
        #1;
        RST = 1'b0;
        chk("rst.busy",   int'(oBUSY),   0);
        chk("rst.valid",  int'(oVALID),  0);
        chk("rst.rd_en0", int'(oRD_EN),  0);
        chk("rst.addr0",  int'(oADDR),   0);
        chk("rst.sum",    int'(oSUM_S),  0);
        chk("rst.cx",     int'(oCX),     0);
        chk("rst.cy",     int'(oCY),     0);
        chk("rst.no_obj", int'(oNO_OBJ), 0);
        chk("rst.err",    int'(oERR),    0);
        // Late row data after reset must be ignored
        iMEMIN   = 16'hFFFF;
        iDATA_EN = 1'b1;
        @(posedge CCLK);
        #1;
        iDATA_EN = 1'b0;
        @(posedge CCLK);
        #1;
        chk("late.busy",  int'(oBUSY),  0);
        chk("late.valid", int'(oVALID), 0);
        chk("late.sum",   int'(oSUM_S), 0);
        chk("late.rd_en", int'(oRD_EN), 0);
        mem_en = 1'b1;

        // Normal operation after the aborted frame
        run_frame("after_rst", 0, 15, 0, 15, 1, 1, 20, 12, 0, 0, 39);

        chk("scoreboard.empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_centroid.md
CALC_CENTROID -- requirements
Module: calc_centroid

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11: row address width and ROI Y coordinate width.
REQ-002 SHALL have parameter MDATA_WIDTH, default 640: pixels per binarized memory row; XW = clog2(MDATA_WIDTH).
REQ-003 SHALL have parameter FRAC_BITS, default 4: fractional bits of centroid outputs; QW = max(XW, ADDR_WIDTH) + FRAC_BITS.
REQ-004 SHALL have port CCLK, in, 1: sole clock, all logic on rising edge.
REQ-005 SHALL have port RST, in, 1: reset, synchronous and active-high.
REQ-006 SHALL have port iSTART, in, 1: one-cycle frame start pulse, honoured only in IDLE.
REQ-007 SHALL have ports iX0/iX1, in, XW each: inclusive ROI column bounds.
REQ-008 SHALL have ports iY0/iY1, in, ADDR_WIDTH each: inclusive ROI row bounds.
REQ-009 SHALL have port iMIN_AREA, in, S_W: minimum pixel count for a valid object; S_W = ADDR_WIDTH + XW + 1.
REQ-010 SHALL have port oRD_EN, out, 1: one-cycle row read request.
REQ-011 SHALL have port oADDR, out, ADDR_WIDTH: requested row, valid with oRD_EN.
REQ-012 SHALL have port iDATA_EN, in, 1: row data valid, arriving 1 or more cycles after oRD_EN.
REQ-013 SHALL have port iMEMIN, in, MDATA_WIDTH: row bitmap; bit i = pixel at column i.
REQ-014 SHALL have port oBUSY, out, 1: high in every state except IDLE.
REQ-015 SHALL have ports oVALID out 1 / iREADY in 1: result handshake.
REQ-016 SHALL have ports oNO_OBJ and oERR, out, 1 each: result status flags.
REQ-017 SHALL have ports oSUM_S out S_W, oCX out QW, oCY out QW: pixel count and centroid in unsigned fixed point (FRAC_BITS fractional bits).

Function
REQ-018 SHALL implement states IDLE, REQ, WAIT, DIV, OUT.
REQ-019 SHALL latch iX0..iY1 and iMIN_AREA on an accepted iSTART and ignore input changes until the next return to IDLE.
REQ-020 SHALL, on accepted iSTART, clear sum registers S, SX, SY, set row to Y0, and go to REQ next cycle.
REQ-021 SHALL, in REQ, assert oRD_EN for exactly one cycle with oADDR = row, then enter WAIT; only one read is outstanding.
REQ-022 SHALL, in WAIT on iDATA_EN, compute over masked bits (X0 <= i <= X1): cnt = popcount; sx = sum of i: S += cnt, SX += sx, SY += row*cnt.
REQ-023 SHALL, on the same cycle as REQ-022, go to REQ with row+1 if row != Y1, else to DIV; iDATA_EN outside WAIT is ignored.
REQ-024 SHALL size accumulators so no overflow is possible: SX width S_W+XW, SY width S_W+ADDR_WIDTH.
REQ-025 SHALL enter DIV only if S >= iMIN_AREA and S != 0; otherwise it SHALL go straight to OUT with oNO_OBJ=1 and oCX=oCY=0.
REQ-026 SHALL compute (SX<<FRAC_BITS)/S and (SY<<FRAC_BITS)/S in DIV with two parallel restoring dividers, one quotient bit per cycle, MSB first, exactly QW cycles, truncating.
REQ-027 SHALL, with 1-cycle memory response, assert oVALID at latency 2*(Y1-Y0+1) + QW + 1 cycles after the iSTART cycle.
REQ-028 SHALL go from DIV to OUT, hold oVALID and all result outputs stable until iREADY=1, then return to IDLE next cycle with oVALID=0.
REQ-029 SHALL treat iX0 > iX1, iY0 > iY1, or iX1 > MDATA_WIDTH-1 as invalid: no reads issued, OUT entered at the cycle after iSTART, oERR=1, oNO_OBJ=1, outputs zero.
REQ-030 SHALL keep the previous oSUM_S/oCX/oCY/flags readable after handshake until the next OUT update.
REQ-031 SHALL ignore iSTART that coincides with the OUT handshake cycle, because the block is not yet in IDLE.

Reset
REQ-032 SHALL, on RST=1 at any state (including mid-WAIT or mid-DIV), enter IDLE next edge with oRD_EN, oBUSY, oVALID, oNO_OBJ, oERR=0, oADDR, oSUM_S, oCX, oCY=0, and discard any late iDATA_EN.

Verification (MDATA_WIDTH=16, ADDR_WIDTH=4, FRAC_BITS=2, ROI 0..15 x 0..15, MIN_AREA=1 unless stated)
REQ-033 SHALL pass: single pixel at (x5, y3) -> oSUM_S=1, oCX=20, oCY=12, oNO_OBJ=0, oVALID at the REQ-027 cycle.
REQ-034 SHALL pass: 2x2 block at x4-5, y6-7 -> S=4, SX=18, SY=26, oCX=18 (4.5), oCY=26 (6.5).
REQ-035 SHALL pass: empty frame -> oNO_OBJ=1, oCX=oCY=0, DIV never entered; with MIN_AREA=5 and a 4-pixel block, the same result.
REQ-036 SHALL pass: row 2 pixels at x1 and x10, ROI x8..15 -> S=1, oCX=40, oCY=8; ROI x0=9, x1=3 -> oERR=1, no oRD_EN.
REQ-037 SHALL pass: iREADY low 10 cycles in OUT -> outputs stable, iSTART pulses ignored; then RST during WAIT -> all outputs 0 next cycle, and a late iDATA_EN produces no accumulation.
